uart_cmd_responder: RTL and testbench

- Host-side command responder on the byte (FIFO) side of the `uart` block.
- Pops command frames from the RX FIFO interface and executes register reads/writes on a simple single-cycle register bus.
- Pushes one response byte per frame into the TX FIFO interface.
- It is the consuming/answering end of the serial link: the PC initiates and this block responds.

---
 rtl/uart_cmd_responder_pkg.sv | 11 +
 rtl/uart_cmd_responder.sv | 78 +++++++
 tb/tb_uart_cmd_responder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_responder_pkg.sv
// uart_cmd_responder_pkg: opcodes, responses and FSM encoding shared by the UART command responder
package uart_cmd_responder_pkg;
    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

    typedef enum logic [2:0] {
        IDLE, GET_ADDR_W, GET_ADDR_R, GET_DATA, BUS_WR, BUS_RD, RD_WAIT, SEND
    } state_t;
endpackage

// File: rtl/uart_cmd_responder.sv
// uart_cmd_responder: pops W/R command frames from the UART RX FIFO, runs them on a
// single-cycle register bus and pushes one ACK/NAK/read-data byte to the TX FIFO.
module uart_cmd_responder
    import uart_cmd_responder_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_empty,
    input  logic [7:0]        r_data,
    output logic              rd_uart,
    input  logic              tx_full,
    output logic [7:0]        w_data,
    output logic              wr_uart,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_we,
    output logic              bus_re,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy,
    output logic [7:0]        err_count
);
    localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state, state_n;
    logic [TW-1:0] tcnt;
    logic          cool, getting, expire, nak;

    always_comb begin
        state_n = state;
        getting = state inside {GET_ADDR_W, GET_ADDR_R, GET_DATA};
        // cool is set for the cycle right after a pop, so pops are never back to back
        rd_uart = (state == IDLE || getting) && !rx_empty && !cool && !reset;
        expire  = getting && !rd_uart && tcnt == T_LAST;
        nak     = state == IDLE && rd_uart && r_data != CMD_WR && r_data != CMD_RD;
        bus_we  = state == BUS_WR && !reset;
        bus_re  = state == BUS_RD && !reset;
        wr_uart = state == SEND && !tx_full && !reset;
        busy    = state != IDLE;
        unique case (state)
            IDLE:       if (rd_uart) state_n = r_data == CMD_WR ? GET_ADDR_W : r_data == CMD_RD ? GET_ADDR_R : SEND;
            GET_ADDR_W: state_n = rd_uart ? GET_DATA : expire ? IDLE : state;
            GET_ADDR_R: state_n = rd_uart ? BUS_RD : expire ? IDLE : state;
            GET_DATA:   state_n = rd_uart ? BUS_WR : expire ? IDLE : state;
            BUS_WR:     state_n = SEND;
            BUS_RD:     state_n = RD_WAIT;
            RD_WAIT:    state_n = SEND;
            SEND:       state_n = tx_full ? SEND : IDLE;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tcnt      <= '0;
            cool      <= 1'b1;
            w_data    <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            err_count <= '0;
        end else begin
            state <= state_n;
            cool  <= rd_uart;
            tcnt  <= getting && !rd_uart && !expire ? tcnt + TW'(1) : '0;
            if (rd_uart && (state == GET_ADDR_W || state == GET_ADDR_R)) bus_addr <= ADDR_W'(r_data);
            if (rd_uart && state == GET_DATA) bus_wdata <= DATA_W'(r_data);
            if (nak) w_data <= RSP_NAK;
            if (state == BUS_WR) w_data <= RSP_ACK;
            if (state == RD_WAIT) w_data <= 8'(bus_rdata);
            if ((nak || expire) && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_uart_cmd_responder.sv
// tb_uart_cmd_responder: frame-level model of the responder with a per-cycle compare process
// against RX FIFO, TX FIFO and register-bus models.
module tb_uart_cmd_responder;
    localparam int TC = 20;

    logic       clk = 0, reset = 1, rx_empty = 1, tx_full = 0;
    logic [7:0] r_data = 0, bus_rdata = 0;
    logic [7:0] w_data, bus_addr, bus_wdata, err_count;
    logic       rd_uart, wr_uart, bus_we, bus_re, busy;

    uart_cmd_responder #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(TC)) dut (
        .clk(clk), .reset(reset), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
        .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata),
        .busy(busy), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef enum int {K_WR, K_RD, K_NAK, K_ABORT} kind_t;
    typedef struct {kind_t kind; int len;} frame_t;
    typedef struct {logic we; logic [7:0] addr; logic [7:0] data;} bus_t;

    frame_t     frames[$];
    bus_t       exp_bus[$];
    logic [7:0] exp_rsp[$];
    logic [7:0] rxq[$];
    logic [7:0] env_mem[256], ref_mem[256];
    int errors = 0, checks = 0, cyc = 0, exp_err = 0;
    int popped = 0, bus_due = -1, rsp_due = 0;
    int n_pop = 0, n_wr = 0, n_we = 0, n_re = 0;
    bit rsp_pending = 0, prev_rd = 0, pend_pop = 0, pend_we = 0, pend_re = 0;
    logic [7:0] pend_addr = 0, pend_data = 0, last_rsp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RX FIFO and register-bus environment; acts on what was sampled at the previous negedge
    always @(posedge clk) begin
        cyc++;
        if (pend_pop && rxq.size() > 0) rxq.delete(0);
        rx_empty <= rxq.size() == 0;
        r_data   <= rxq.size() > 0 ? rxq[0] : 8'h00;
        if (pend_we) env_mem[pend_addr] = pend_data;
        if (pend_re) bus_rdata <= env_mem[pend_addr];
    end

    always @(negedge clk) begin : cmp
        bus_t e;
        pend_pop = rd_uart; pend_we = bus_we; pend_re = bus_re;
        pend_addr = bus_addr; pend_data = bus_wdata;
        if (reset) begin
            frames.delete(); exp_bus.delete(); exp_rsp.delete();
            popped = 0; rsp_pending = 0; bus_due = -1;
        end else begin
            chk("pop_legal", rd_uart && (rx_empty || prev_rd), 0);
            chk("bus_strobe_timing", bus_we || bus_re, cyc == bus_due);
            if (bus_we || bus_re) begin
                n_we += int'(bus_we); n_re += int'(bus_re);
                if (exp_bus.size() == 0) chk("bus_unexpected", 1, 0);
                else begin
                    e = exp_bus.pop_front();
                    chk("bus_kind_we", bus_we, e.we);
                    chk("bus_addr", bus_addr, e.addr);
                    if (bus_we) chk("bus_wdata", bus_wdata, e.data);
                end
            end
            if (wr_uart) begin
                n_wr++; last_rsp = w_data;
                chk("rsp_timing", rsp_pending && cyc >= rsp_due, 1);
                if (exp_rsp.size() == 0) chk("rsp_unexpected", 1, 0);
                else chk("rsp_byte", w_data, exp_rsp.pop_front());
                rsp_pending = 0;
            end else if (rsp_pending && cyc >= rsp_due && !tx_full) chk("rsp_late", 1, 0);
            if (rd_uart) begin
                n_pop++;
                if (frames.size() == 0) chk("pop_unexpected", 1, 0);
                else if (++popped == frames[0].len) begin
                    case (frames[0].kind)
                        K_WR:    begin bus_due = cyc + 1; rsp_due = cyc + 2; rsp_pending = 1; end
                        K_RD:    begin bus_due = cyc + 1; rsp_due = cyc + 3; rsp_pending = 1; end
                        K_NAK:   begin rsp_due = cyc + 1; rsp_pending = 1; end
                        default: ;
                    endcase
                    frames.delete(0);
                    popped = 0;
                end
            end
        end
        prev_rd = rd_uart;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Queue one frame's bytes and what it must produce; gap = idle cycles between bytes
    task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d, input int gap);
        frame_t f;
        bus_t   b;
        if (op == 8'h57) begin
            f.kind = K_WR; f.len = 3;
            b.we = 1; b.addr = a; b.data = d;
            exp_bus.push_back(b); exp_rsp.push_back(8'h06); ref_mem[a] = d;
        end else if (op == 8'h52) begin
            f.kind = K_RD; f.len = 2;
            b.we = 0; b.addr = a; b.data = 0;
            exp_bus.push_back(b); exp_rsp.push_back(ref_mem[a]);
        end else begin
            f.kind = K_NAK; f.len = 1;
            exp_rsp.push_back(8'h15);
            if (exp_err < 255) exp_err++;
        end
        frames.push_back(f);
        rxq.push_back(op);
        if (f.len > 1) begin tick(gap); rxq.push_back(a); end
        if (f.len > 2) begin tick(gap); rxq.push_back(d); end
    endtask

    task automatic abort_frame(input logic [7:0] op, input logic [7:0] a);
        frame_t f;
        f.kind = K_ABORT; f.len = 2;
        frames.push_back(f);
        rxq.push_back(op); rxq.push_back(a);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        tick(1);
        while ((rxq.size() > 0 || frames.size() > 0 || exp_bus.size() > 0 || rsp_pending || busy) && n < 2000) begin
            tick(1); n++;
        end
        chk({name, "_done"}, n < 2000, 1);
        chk({name, "_err_count"}, err_count, exp_err);
    endtask

    task automatic do_reset(input int n);
        reset = 1;
        rxq.delete();
        exp_err = 0;
        tick(n);
        reset = 0;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_rd_uart"}, rd_uart, 0);
        chk({name, "_wr_uart"}, wr_uart, 0);
        chk({name, "_bus_we"}, bus_we, 0);
        chk({name, "_bus_re"}, bus_re, 0);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_err_count"}, err_count, 0);
        chk({name, "_w_data"}, w_data, 0);
        chk({name, "_bus_addr"}, bus_addr, 0);
        chk({name, "_bus_wdata"}, bus_wdata, 0);
    endtask

    initial begin
        #300000;
        errors++;
        $display("FAIL global_timeout: simulation did not complete");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int base, wr0, we0, re0, n;
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 8'(i * 3 + 1);
            ref_mem[i] = 8'(i * 3 + 1);
        end
        env_mem[8'h22] = 8'h3C; ref_mem[8'h22] = 8'h3C;
        do_reset(3);
        chk_zero("reset");

        base = n_pop;
        send_frame(8'h57, 8'h10, 8'hA5, 0);
        wait_idle("write");
        chk("write_pops", n_pop - base, 3);
        chk("write_mem", env_mem[8'h10], 8'hA5);
        chk("write_ack", last_rsp, 8'h06);
        chk("write_addr_hold", bus_addr, 8'h10);
        chk("write_wdata_hold", bus_wdata, 8'hA5);

        re0 = n_re;
        send_frame(8'h52, 8'h22, 8'h00, 0);
        wait_idle("read");
        chk("read_data", last_rsp, 8'h3C);
        chk("read_strobes", n_re - re0, 1);

        we0 = n_we; re0 = n_re;
        send_frame(8'h41, 8'h00, 8'h00, 0);
        wait_idle("nak");
        chk("nak_byte", last_rsp, 8'h15);
        chk("nak_err", err_count, 1);
        chk("nak_no_bus", n_we + n_re - we0 - re0, 0);

        send_frame(8'h57, 8'h44, 8'hC3, 15);
        wait_idle("slow_write");
        chk("slow_write_ack", last_rsp, 8'h06);

        wr0 = n_wr; we0 = n_we;
        abort_frame(8'h57, 8'h10);
        n = 0;
        while ((rxq.size() > 0 || frames.size() > 0) && n < 100) begin tick(1); n++; end
        chk("timeout_bytes_popped", n < 100, 1);
        tick(25);
        exp_err++;
        chk("timeout_busy", busy, 0);
        chk("timeout_err", err_count, exp_err);
        chk("timeout_no_rsp", n_wr - wr0, 0);
        chk("timeout_no_we", n_we - we0, 0);
        send_frame(8'h52, 8'h10, 8'h00, 0);
        wait_idle("after_timeout");
        chk("after_timeout_read", last_rsp, 8'hA5);

        wr0 = n_wr; base = n_pop;
        tx_full = 1;
        send_frame(8'h57, 8'h33, 8'h5E, 0);
        tick(16);
        chk("bp_no_wr", n_wr - wr0, 0);
        chk("bp_pops", n_pop - base, 3);
        chk("bp_busy", busy, 1);
        tx_full = 0;
        wait_idle("backpressure");
        chk("bp_one_wr", n_wr - wr0, 1);
        chk("bp_ack", last_rsp, 8'h06);

        we0 = n_we; wr0 = n_wr; base = n_pop;
        abort_frame(8'h57, 8'h10);
        n = 0;
        while (n_pop - base < 2 && n < 100) begin tick(1); n++; end
        chk("midreset_popped", n_pop - base, 2);
        do_reset(1);
        chk_zero("midreset");
        send_frame(8'h52, 8'h10, 8'h00, 0);
        wait_idle("midreset_read");
        chk("midreset_read", last_rsp, 8'hA5);
        chk("midreset_no_we", n_we - we0, 0);
        chk("midreset_one_rsp", n_wr - wr0, 1);

        for (int i = 0; i < 260; i++) send_frame(8'h41, 8'h00, 8'h00, 0);
        wait_idle("saturate");
        chk("saturate_err", err_count, 8'hFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
